ps2_cmd_sequencer: RTL and testbench
====================================

Name: ps2_cmd_sequencer

Overview:
- Sits between the PS2_Controller byte stream (received_data / received_data_en) and the blackjack game FSM.
- Parses PS/2 set-2 make/break/extended framing and tracks the held state of H, S and D so that typematic repeats produce no extra commands.
- Queues decoded commands in a small FIFO, delivered to the game FSM through a valid/ready handshake.
- Replaces the single-cycle pulse outputs, which lose presses while the game FSM is busy.

Parameters:
- FIFO_DEPTH, 4, command queue depth; power of two, minimum 2.
- TIMEOUT_CYC, 2500000, idle cycles (50 ms at 50 MHz) after which a pending prefix state is abandoned.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- rx_data  in  8  scan-code byte from the PS2 controller.
- rx_en  in  1  one-cycle strobe; rx_data is valid while rx_en is high.
- flush  in  1  synchronous; empties the FIFO and clears all held flags.
- cmd_ready  in  1  game FSM accepts the head command.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  2  head command: 0 = HIT, 1 = STAND, 2 = DEAL; 3 is never produced.
- held  out  3  live key state, bit 0 = H, bit 1 = S, bit 2 = D.
- overflow  out  1  sticky; a command was dropped because the FIFO was full.
- last_code  out  8  last non-prefix byte received, for LED debug.

Behaviour:
- Reset (async, resetn = 0): parser in IDLE, FIFO empty, cmd_valid = 0, cmd_code = 0, held = 0, overflow = 0, last_code = 0, timeout counter = 0.
- Constants: H = 8'h33, S = 8'h1B, D = 8'h23, BRK = 8'hF0, EXT = 8'hE0.
- Parser FSM states: IDLE, BREAK, EXT, EXT_BREAK. All transitions occur only on cycles with rx_en = 1 (except timeout).
  - IDLE:
    - byte F0 -> BREAK.
    - byte E0 -> EXT.
    - byte H/S/D with its held bit 0: set the held bit and push the command; stay in IDLE.
    - byte H/S/D with its held bit 1: typematic repeat; no push.
    - any other byte: ignored.
  - BREAK: any byte -> IDLE. If the byte is H/S/D, clear that held bit; otherwise nothing.
  - EXT: byte F0 -> EXT_BREAK; any other byte -> IDLE with no action (extended keys are never commands).
  - EXT_BREAK: any byte -> IDLE with no action.
- Timeout:
  - The counter runs only while the parser is in a non-IDLE state and resets on every rx_en.
  - When the counter reaches TIMEOUT_CYC - 1, the parser returns to IDLE. Held flags are unchanged.
- last_code updates on every rx_en whose byte is not F0 or E0.
- Latency: rx_en high in cycle N with a new H make code and an empty FIFO -> cmd_valid = 1 and cmd_code valid from cycle N+1.
- FIFO:
  - Pop when cmd_valid & cmd_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (occupancy unchanged).
  - Push while full with no pop: the command is dropped, overflow is set, and the held bit is still set. overflow clears only on reset or flush.
  - cmd_code always reflects the head entry; it is stable while cmd_valid = 1 and cmd_ready = 0.
- flush has priority over push and pop in the same cycle:
  - FIFO empty, held = 0, overflow = 0, parser -> IDLE.
  - A byte arriving in the flush cycle is discarded.
- Pointer arithmetic: log2(FIFO_DEPTH)-bit read/write pointers wrap naturally; occupancy is a separate counter of log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code localparams H_KEY, S_KEY, D_KEY, BRK_CODE, EXT_CODE;
  - command encodings CMD_HIT, CMD_STAND, CMD_DEAL;
  - parser state encodings.
- One sub-module, ps2_cmd_fifo: parameterised synchronous FIFO with push, pop, flush, full, empty and head output. The parser, held tracking and timeout stay in the top level.

Test Plan:
- Press sequence 33, F0 33 with cmd_ready = 1 -> exactly one cmd_valid pulse, with cmd_code = 0, one cycle after the first rx_en; held[0] goes 1 then 0.
- Typematic sequence 1B, 1B, 1B, F0 1B -> exactly one STAND (code 1) queued; held[1] = 1 until the break byte.
- Extended and non-command bytes E0 33, E0 F0 33, then 23 -> only DEAL (code 2) queued; held = 3'b100; last_code = 8'h23.
- Full FIFO with cmd_ready = 0: five distinct make/break cycles of H -> occupancy 4, overflow = 1, head still code 0. flush -> cmd_valid = 0, overflow = 0.
- Send F0 and no further byte for TIMEOUT_CYC cycles, then 33 -> a HIT is queued, not interpreted as a break.
- Assert resetn low mid-queue with 2 entries and held = 3'b011 -> all outputs 0 immediately (async), FIFO empty after release.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, command encodings and parser states for the
// PS/2 command sequencer.
package ps2_pkg;

    localparam logic [7:0] H_KEY    = 8'h33;
    localparam logic [7:0] S_KEY    = 8'h1B;
    localparam logic [7:0] D_KEY    = 8'h23;
    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    localparam logic [1:0] CMD_HIT   = 2'd0;
    localparam logic [1:0] CMD_STAND = 2'd1;
    localparam logic [1:0] CMD_DEAL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } parser_state_t;

    // {is_command_key, command}; the command doubles as the held-bit index.
    function automatic logic [2:0] key_decode(input logic [7:0] code);
        case (code)
            H_KEY:   key_decode = {1'b1, CMD_HIT};
            S_KEY:   key_decode = {1'b1, CMD_STAND};
            D_KEY:   key_decode = {1'b1, CMD_DEAL};
            default: key_decode = {1'b0, 2'b00};
        endcase
    endfunction

endpackage

// File: rtl/ps2_cmd_fifo.sv
// Small synchronous command FIFO; push while full is honoured only when a pop
// happens in the same cycle.
module ps2_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign empty     = (count_r == (AW+1)'(0));
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 2'b00;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Turns a PS/2 set-2 byte stream into queued HIT/STAND/DEAL commands,
// suppressing typematic repeats by tracking which keys are held.
module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_en,
    input  logic       flush,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [2:0] held,
    output logic       overflow,
    output logic [7:0] last_code
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    parser_state_t state_r, state_n;
    logic [2:0]    held_r, held_n;
    logic          overflow_r;
    logic [7:0]    last_code_r;
    logic [CW-1:0] tmo_cnt_r;
    logic          tmo_hit_s;
    logic [2:0]    dec_s;
    logic          key_hit_s;
    logic [1:0]    key_idx_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;

    assign dec_s     = key_decode(rx_data);
    assign key_hit_s = dec_s[2];
    assign key_idx_s = dec_s[1:0];
    assign tmo_hit_s = (tmo_cnt_r == CW'(TIMEOUT_CYC - 1));
    assign pop_s     = ~empty_s & cmd_ready;

    // Parser state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            held_r  <= 3'b000;
        end else begin
            state_r <= state_n;
            held_r  <= held_n;
        end
    end

    // Prefix parsing, held-key tracking and command generation.
    always_comb begin
        state_n = state_r;
        held_n  = held_r;
        push_s  = 1'b0;
        if (flush) begin
            state_n = ST_IDLE;
            held_n  = 3'b000;
        end else if (rx_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == BRK_CODE) begin
                        state_n = ST_BREAK;
                    end else if (rx_data == EXT_CODE) begin
                        state_n = ST_EXT;
                    end else if (key_hit_s && !held_r[key_idx_s]) begin
                        held_n[key_idx_s] = 1'b1;
                        push_s            = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    state_n = ST_IDLE;
                    if (key_hit_s) held_n[key_idx_s] = 1'b0;
                    else           held_n = held_r;
                end
                ST_EXT: begin
                    if (rx_data == BRK_CODE) state_n = ST_EXT_BREAK;
                    else                     state_n = ST_IDLE;
                end
                ST_EXT_BREAK: state_n = ST_IDLE;
                default:      state_n = ST_IDLE;
            endcase
        end else if (state_r != ST_IDLE && tmo_hit_s) begin
            state_n = ST_IDLE;
        end else begin
            state_n = state_r;
        end
    end

    // Idle counter that abandons a dangling F0/E0 prefix.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_r <= '0;
        end else if (flush || rx_en || state_r == ST_IDLE || tmo_hit_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end
    end

    // Sticky overflow and debug copy of the last non-prefix byte.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            overflow_r  <= 1'b0;
            last_code_r <= 8'h00;
        end else if (flush) begin
            overflow_r  <= 1'b0;
        end else begin
            if (push_s && full_s && !pop_s) overflow_r <= 1'b1;
            if (rx_en && rx_data != BRK_CODE && rx_data != EXT_CODE) last_code_r <= rx_data;
        end
    end

    ps2_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .flush     (flush),
        .push      (push_s),
        .push_data (key_idx_s),
        .pop       (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .head      (cmd_code)
    );

    assign cmd_valid = ~empty_s;
    assign held      = held_r;
    assign overflow  = overflow_r;
    assign last_code = last_code_r;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: a queue-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_ps2_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en = 1'b0;
    logic       flush = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [2:0] held;
    logic       overflow;
    logic [7:0] last_code;

    int total = 0;
    int bad   = 0;

    ps2_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_en     (rx_en),
        .flush     (flush),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .held      (held),
        .overflow  (overflow),
        .last_code (last_code)
    );

    always #5 clk = ~clk;

    // Reference model: queue of commands, held keys, pending prefix flags.
    int         m_q[$];
    logic [2:0] m_held;
    logic       m_ovf;
    logic [7:0] m_last;
    logic       m_brk, m_ext;
    int         m_idle;

    function automatic int key_cmd(input logic [7:0] b);
        if (b == 8'h33) return 0;
        if (b == 8'h1B) return 1;
        if (b == 8'h23) return 2;
        return -1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_held = 3'b000; m_ovf = 1'b0; m_last = 8'h00;
            m_brk = 1'b0; m_ext = 1'b0; m_idle = 0;
        end else begin
            int  k;
            int  code;
            bit  pop;
            pop  = (m_q.size() > 0) && cmd_ready;
            code = -1;
            k    = key_cmd(rx_data);
            if (flush) begin
                m_q.delete();
                m_held = 3'b000; m_ovf = 1'b0;
                m_brk = 1'b0; m_ext = 1'b0; m_idle = 0;
                pop = 1'b0;
            end else if (rx_en) begin
                m_idle = 0;
                if (rx_data != 8'hF0 && rx_data != 8'hE0) m_last = rx_data;
                if (!m_brk && !m_ext) begin
                    if (rx_data == 8'hF0) m_brk = 1'b1;
                    else if (rx_data == 8'hE0) m_ext = 1'b1;
                    else if (k >= 0 && !m_held[k]) begin
                        m_held[k] = 1'b1;
                        code = k;
                    end
                end else if (m_brk && !m_ext) begin
                    m_brk = 1'b0;
                    if (k >= 0) m_held[k] = 1'b0;
                end else if (m_ext && !m_brk) begin
                    if (rx_data == 8'hF0) m_brk = 1'b1;
                    else m_ext = 1'b0;
                end else begin
                    m_brk = 1'b0; m_ext = 1'b0;
                end
            end else if (m_brk || m_ext) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_brk = 1'b0; m_ext = 1'b0; m_idle = 0;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (code >= 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(code);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (resetn) begin
            cmp("model_valid", {7'd0, cmd_valid}, {7'd0, m_q.size() > 0});
            if (m_q.size() > 0) cmp("model_code", {6'd0, cmd_code}, 8'(m_q[0]));
            cmp("model_held", {5'd0, held}, {5'd0, m_held});
            cmp("model_ovf", {7'd0, overflow}, {7'd0, m_ovf});
            cmp("model_last", last_code, m_last);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_en   = 1'b1;
        @(negedge clk);
        rx_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_valid"}, {7'd0, cmd_valid}, 8'h00);
        cmp({tag, "_code"},  {6'd0, cmd_code},  8'h00);
        cmp({tag, "_held"},  {5'd0, held},      8'h00);
        cmp({tag, "_ovf"},   {7'd0, overflow},  8'h00);
        cmp({tag, "_last"},  last_code,         8'h00);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        idle(2);
        resetn = 1'b1;
        idle(1);

        // Press and release H with the consumer ready.
        cmd_ready = 1'b1;
        send(8'h33);
        cmp("hit_valid", {7'd0, cmd_valid}, 8'h01);
        cmp("hit_code",  {6'd0, cmd_code},  8'h00);
        cmp("hit_held",  {5'd0, held},      8'h01);
        idle(1);
        cmp("hit_popped", {7'd0, cmd_valid}, 8'h00);
        send(8'hF0); send(8'h33);
        cmp("hit_release", {5'd0, held}, 8'h00);

        // Typematic repeats of S queue one STAND.
        cmd_ready = 1'b0;
        send(8'h1B); send(8'h1B); send(8'h1B);
        cmp("stand_code", {6'd0, cmd_code}, 8'h01);
        cmp("stand_held", {5'd0, held},     8'h02);
        send(8'hF0); send(8'h1B);
        cmp("stand_release", {5'd0, held}, 8'h00);
        cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0;
        cmp("stand_single", {7'd0, cmd_valid}, 8'h00);

        // Extended keys ignored; plain D deals.
        send(8'hE0); send(8'h33); send(8'hE0); send(8'hF0); send(8'h33); send(8'h23);
        cmp("deal_code", {6'd0, cmd_code}, 8'h02);
        cmp("deal_held", {5'd0, held},     8'h04);
        cmp("deal_last", last_code,        8'h23);
        send(8'hF0); send(8'h23);
        cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0;
        cmp("deal_single", {7'd0, cmd_valid}, 8'h00);

        // Overfill the queue.
        for (int i = 0; i < 5; i++) begin
            send(8'h33); send(8'hF0); send(8'h33);
        end
        cmp("full_ovf",  {7'd0, overflow}, 8'h01);
        cmp("full_code", {6'd0, cmd_code}, 8'h00);
        cmd_ready = 1'b1; idle(3); cmd_ready = 1'b0;
        cmp("full_occ4", {7'd0, cmd_valid}, 8'h01);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        cmp("flush_valid", {7'd0, cmd_valid}, 8'h00);
        cmp("flush_ovf",   {7'd0, overflow},  8'h00);

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) begin
            send(8'h33); send(8'hF0); send(8'h33);
        end
        @(negedge clk);
        rx_data = 8'h1B; rx_en = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        rx_en = 1'b0; cmd_ready = 1'b0;
        cmp("fullpp_ovf",  {7'd0, overflow}, 8'h00);
        cmp("fullpp_held", {5'd0, held},     8'h02);

        // Byte in the flush cycle is discarded.
        @(negedge clk);
        flush = 1'b1; rx_data = 8'h23; rx_en = 1'b1;
        @(negedge clk);
        flush = 1'b0; rx_en = 1'b0;
        cmp("flushrx_valid", {7'd0, cmd_valid}, 8'h00);
        cmp("flushrx_held",  {5'd0, held},      8'h00);

        // Abandoned break prefix times out; a short gap does not.
        send(8'hF0); idle(TMO + 2); send(8'h33);
        cmp("tmo_valid", {7'd0, cmd_valid}, 8'h01);
        cmp("tmo_held",  {5'd0, held},      8'h01);
        send(8'hF0); idle(TMO / 2); send(8'h33);
        cmp("notmo_held", {5'd0, held}, 8'h00);
        cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0;

        // Asynchronous reset with two entries queued.
        send(8'h33); send(8'h1B);
        cmp("prerst_held", {5'd0, held}, 8'h03);
        #2 resetn = 1'b0;
        #1 check_all_zero("async_rst");
        idle(2);
        resetn = 1'b1;
        idle(2);
        cmp("postrst_valid", {7'd0, cmd_valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
